// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the responder state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HSIZE_BYTE    = 2'b00;
  localparam logic [1:0] HSIZE_HALF    = 2'b01;
  localparam logic [1:0] HSIZE_WORD    = 2'b10;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } resp_state_t;
endpackage

// File: rtl/ahb_sram_responder_if.sv
// ahb_sram_responder_if: AHB-Lite slave-side bus bundle with master/slave views
interface ahb_sram_responder_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_byte_strobe.sv
// ahb_byte_strobe: decodes transfer size and low address bits into a byte-lane mask and an illegal flag
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [1:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       illegal
);
  assign illegal = (hsize == 2'b11) |
                   ((hsize == HSIZE_HALF) & addr_lo[0]) |
                   ((hsize == HSIZE_WORD) & (|addr_lo));
  assign mask = hsize == HSIZE_BYTE ? 4'b0001 << addr_lo :
                hsize == HSIZE_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
endmodule

// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: AHB-Lite SRAM slave with WAIT_STATES wait cycles per OKAY
// data phase and two-cycle ERROR responses for illegal size/alignment.
module ahb_sram_responder
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_sram_responder_if.slave bus
);
  resp_state_t           state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  write_q, write_d;
  logic [3:0]            mask_q, mask_d;
  logic [3:0]            mask;
  logic                  illegal;
  logic                  valid;
  logic                  mem_we;
  logic                  unused_bits;
  logic [31:0]           mem [2**ADDR_WIDTH];
  ahb_byte_strobe u_strobe (
    .hsize  (bus.HSIZE),
    .addr_lo(bus.HADDR[1:0]),
    .mask   (mask),
    .illegal(illegal)
  );
  assign valid       = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign unused_bits = ^{bus.HBURST, bus.HTRANS[0], bus.HADDR[31:ADDR_WIDTH+2]};
  // New address phases are only taken when no data phase is stalling the bus
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    mask_d  = mask_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = cnt_q == 3'd1 ? ST_DATA : ST_WAIT;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (valid) begin
          idx_d   = bus.HADDR[ADDR_WIDTH+1:2];
          write_d = bus.HWRITE & ~illegal;
          mask_d  = mask;
          state_d = illegal ? ST_ERR1 : WAIT_STATES == 0 ? ST_DATA : ST_WAIT;
          cnt_d   = illegal ? 3'd0 : 3'(WAIT_STATES);
        end
      end
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      mask_q  <= mask_d;
    end
  end
  // Write lands at the edge that closes the data phase, when HWDATA is valid
  assign mem_we = (state_q == ST_DATA) & write_q;
  always_ff @(posedge HCLK) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mask_q[i]) mem[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
  end
  assign bus.HREADYOUT = !(state_q inside {ST_WAIT, ST_ERR1});
  assign bus.HRESP     = (state_q inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA    = (state_q == ST_DATA && !write_q) ? mem[idx_q] : '0;
endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb_ahb_sram_responder: three responders (0, 3 and 1 wait states) on one master,
// checked against a byte-addressed memory model and protocol timing rules.
module tb_ahb_sram_responder;
  import ahb_pkg::*;
  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  hsize;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [1:0]  sel;
  logic        rdy_a [3];
  logic        resp_a [3];
  logic [31:0] rdata_a [3];
  logic        bus_rdy, bus_resp;
  logic [31:0] bus_rdata;
  logic [31:0] model [3][256];
  logic [31:0] last_rdata;
  beat_t       bq [$];
  int          vectors = 0;
  int          errs = 0;
  always #5 clk = ~clk;
  assign bus_rdy   = sel == 2'd0 ? rdy_a[0]   : sel == 2'd1 ? rdy_a[1]   : rdy_a[2];
  assign bus_resp  = sel == 2'd0 ? resp_a[0]  : sel == 2'd1 ? resp_a[1]  : resp_a[2];
  assign bus_rdata = sel == 2'd0 ? rdata_a[0] : sel == 2'd1 ? rdata_a[1] : rdata_a[2];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_responder_if bi ();
    assign bi.HSEL   = hsel && (sel == 2'(g));
    assign bi.HADDR  = haddr;
    assign bi.HWRITE = hwrite;
    assign bi.HSIZE  = hsize;
    assign bi.HTRANS = htrans;
    assign bi.HBURST = hburst;
    assign bi.HWDATA = hwdata;
    assign bi.HREADY = bus_rdy;
    assign rdy_a[g]   = bi.HREADYOUT;
    assign resp_a[g]  = bi.HRESP;
    assign rdata_a[g] = bi.HRDATA;
    ahb_sram_responder #(
      .ADDR_WIDTH (8),
      .WAIT_STATES(g == 1 ? 3 : g == 2 ? 1 : 0)
    ) u_dut (
      .HCLK   (clk),
      .HRESETn(rst_n),
      .bus    (bi.slave)
    );
  end
  function automatic int ws(input int d);
    return d == 1 ? 3 : d == 2 ? 1 : 0;
  endfunction
  function automatic logic is_illegal(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction
  task automatic mwrite(input int d, input beat_t b);
    int n, ba, lane;
    n = 1 << b.size;
    for (int k = 0; k < n; k++) begin
      ba   = int'(b.addr) + k;
      lane = ba % 4;
      model[d][(ba / 4) % 256][lane*8 +: 8] = b.wdata[lane*8 +: 8];
    end
  endtask
  task automatic push(input logic [1:0] t, input logic w, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] wd);
    beat_t b;
    b.trans = t; b.wr = w; b.size = s; b.addr = a; b.wdata = wd;
    bq.push_back(b);
  endtask
  // Pipelined master: drives queued beats and checks each data phase on the falling edge
  task automatic run(input int d);
    beat_t       dp, b;
    bit          dp_v;
    int          waits, guard, exp_w;
    logic        exp_ill;
    logic [31:0] exp_rd;
    dp_v = 0; waits = 0; guard = 0;
    sel = 2'(d);
    while ((bq.size() > 0 || dp_v) && guard < 500) begin
      guard++;
      if (bq.size() > 0) begin
        hsel = 1'b1; htrans = bq[0].trans; hwrite = bq[0].wr; hsize = bq[0].size; haddr = bq[0].addr;
      end else begin
        hsel = 1'b0; htrans = HTRANS_IDLE;
      end
      hwdata = dp_v ? dp.wdata : 32'h0;
      @(negedge clk);
      if (dp_v) begin
        exp_ill = is_illegal(dp.size, dp.addr);
        if (!bus_rdy) begin
          waits++;
          vectors++;
          if (bus_resp !== exp_ill || bus_rdata !== 32'h0)
            $display("FAIL wait_cycle dut%0d addr=%h: resp=%b rdata=%h, want resp=%b rdata=0", d, dp.addr, bus_resp, bus_rdata, exp_ill);
          for (int k = 0; k < 3; k++) if (k != d) begin
            vectors++;
            if (rdy_a[k] !== 1'b1 || resp_a[k] !== 1'b0) begin
              errs++;
              $display("FAIL idle_other dut%0d: ready=%b resp=%b, want 1/0", k, rdy_a[k], resp_a[k]);
            end
          end
          if (bus_resp !== exp_ill || bus_rdata !== 32'h0) errs++;
        end else begin
          exp_w  = exp_ill ? 1 : ws(d);
          exp_rd = (!exp_ill && !dp.wr) ? model[d][dp.addr[9:2]] : 32'h0;
          vectors++;
          if (waits != exp_w) begin
            errs++;
            $display("FAIL wait_count dut%0d addr=%h: got %0d cycles, want %0d", d, dp.addr, waits, exp_w);
          end
          vectors++;
          if (bus_resp !== exp_ill) begin
            errs++;
            $display("FAIL final_resp dut%0d addr=%h: got %b, want %b", d, dp.addr, bus_resp, exp_ill);
          end
          vectors++;
          if (bus_rdata !== exp_rd) begin
            errs++;
            $display("FAIL rdata dut%0d addr=%h wr=%b: got %h, want %h", d, dp.addr, dp.wr, bus_rdata, exp_rd);
          end
          last_rdata = bus_rdata;
          if (!exp_ill && dp.wr) mwrite(d, dp);
          dp_v = 0;
        end
      end else begin
        vectors++;
        if (bus_rdy !== 1'b1 || bus_resp !== 1'b0) begin
          errs++;
          $display("FAIL zero_wait_okay dut%0d: ready=%b resp=%b, want 1/0", d, bus_rdy, bus_resp);
        end
      end
      if (bus_rdy && bq.size() > 0) begin
        b = bq.pop_front();
        if (b.trans[1]) begin dp = b; dp_v = 1; waits = 0; end
      end
      @(posedge clk); #1;
    end
    if (guard >= 500) begin
      errs++;
      $display("FAIL timeout dut%0d: transfer did not complete, %0d beats left", d, bq.size());
      bq.delete();
    end
    hsel = 1'b0; htrans = HTRANS_IDLE;
  endtask
  task automatic test_reset;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rdy_a[k] !== 1'b1 || resp_a[k] !== 1'b0 || rdata_a[k] !== 32'h0) begin
        errs++;
        $display("FAIL reset_values dut%0d: ready=%b resp=%b rdata=%h, want 1/0/0", k, rdy_a[k], resp_a[k], rdata_a[k]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back;
    push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    run(0);
    vectors++;
    if (last_rdata !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL b2b_read: got %h, want deadbeef", last_rdata);
    end
  endtask
  task automatic test_wait_states;
    logic [31:0] v;
    v = $urandom;
    push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h04, v);
    run(1);
    push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04, 32'h0);
    run(1);
    vectors++;
    if (last_rdata !== v) begin
      errs++;
      $display("FAIL wait_read: got %h, want %h", last_rdata, v);
    end
  endtask
  task automatic test_byte_lanes;
    push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
    push(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h21, 32'h0000AA00);
    push(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h22, 32'h55660000);
    push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    run(0);
    vectors++;
    if (last_rdata !== 32'h5566AA00) begin
      errs++;
      $display("FAIL lane_merge: got %h, want 5566aa00", last_rdata);
    end
  endtask
  task automatic test_errors;
    push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h00, 32'h11223344);
    push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h02, 32'hFFFFFFFF);
    push(HTRANS_NONSEQ, 1'b1, 2'b11,      32'h00, 32'hEEEEEEEE);
    push(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h01, 32'hDDDDDDDD);
    push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'h0);
    run(0);
    vectors++;
    if (last_rdata !== 32'h11223344) begin
      errs++;
      $display("FAIL error_no_write: got %h, want 11223344", last_rdata);
    end
  endtask
  task automatic test_burst_busy;
    logic [31:0] w [4];
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    hburst = 3'b011;
    push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, w[0]);
    push(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h44, w[1]);
    push(HTRANS_BUSY,   1'b1, HSIZE_WORD, 32'h48, 32'h0);
    push(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h48, w[2]);
    push(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h4C, w[3]);
    run(2);
    for (int k = 0; k < 4; k++)
      push(k == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h40 + 32'(4 * k), 32'h0);
    run(2);
    hburst = 3'b000;
    vectors++;
    if (last_rdata !== w[3]) begin
      errs++;
      $display("FAIL burst_last: got %h, want %h", last_rdata, w[3]);
    end
  endtask
  task automatic test_reset_mid;
    push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h08, 32'hCAFE0001);
    run(1);
    sel = 2'd1; hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h08;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hBAD0BAD0;
    @(negedge clk);
    vectors++;
    if (bus_rdy !== 1'b0) begin
      errs++;
      $display("FAIL pre_reset_wait: ready=%b, want 0", bus_rdy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_rdy !== 1'b1 || bus_resp !== 1'b0 || bus_rdata !== 32'h0) begin
      errs++;
      $display("FAIL async_reset: ready=%b resp=%b rdata=%h, want 1/0/0", bus_rdy, bus_resp, bus_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h08, 32'h0);
    run(1);
    vectors++;
    if (last_rdata !== 32'hCAFE0001) begin
      errs++;
      $display("FAIL aborted_write: got %h, want cafe0001", last_rdata);
    end
  endtask
  task automatic test_random;
    int r;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 16; k++) push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h100 + 32'(4 * k), $urandom);
      run(d);
      for (int k = 0; k < 40; k++) begin
        r = $urandom_range(0, 7);
        push(r == 0 ? HTRANS_IDLE : r == 1 ? HTRANS_BUSY : r[0] ? HTRANS_SEQ : HTRANS_NONSEQ,
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             32'h100 + 32'($urandom_range(0, 63)), $urandom);
      end
      run(d);
    end
  endtask
  initial begin
    rst_n = 1'b0; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hsize = '0;
    htrans = HTRANS_IDLE; hburst = '0; hwdata = '0; sel = '0; last_rdata = '0;
    repeat (3) @(posedge clk);
    test_reset;
    test_back_to_back;
    test_wait_states;
    test_byte_lanes;
    test_errors;
    test_burst_busy;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/ahb_sram_responder.md
# ahb_sram_responder

AHB-Lite responder: a zero-to-N wait-state SRAM slave that sits behind one per-slave arbiter in the multimaster fabric. It implements the slave end of the protocol that the bus master interfaces initiate. It accepts pipelined address/data phases, performs byte-lane writes and word reads, and returns two-cycle ERROR responses for illegal transfers. It also drives HREADYOUT/HRESP/HRDATA into the response multiplexer.

## Interface
- ADDR_WIDTH, 8, word-index bits; memory depth = 2**ADDR_WIDTH 32-bit words
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase (legal 0..7)
- HCLK  in  1  bus clock, all state on rising edge
- HRESETn  in  1  reset; asynchronous, active-low
- HSEL  in  1  slave select from decoder/arbiter
- HADDR  in  32  byte address; word index = HADDR[ADDR_WIDTH+1:2]
- HWRITE  in  1  1 = write
- HSIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HBURST  in  3  ignored; bursts handled as individual beats
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus-level ready (previous transfer complete)
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 OKAY, 1 ERROR

## Operation
- Valid address phase = HSEL & HTRANS[1] & HREADY on a rising edge; capture HADDR, HWRITE, HSIZE into data-phase registers.
- IDLE/BUSY or unselected transfers get zero-wait OKAY and cause no access.
- Illegal transfer: HSIZE=11, halfword with HADDR[0]=1, or word with HADDR[1:0]≠0. No memory write occurs.
- States:
  - ST_IDLE: no data phase pending; HREADYOUT=1, HRESP=0.
  - ST_WAIT: HREADYOUT=0, HRESP=0; counter decrements.
  - ST_DATA: final OKAY cycle; HREADYOUT=1, HRESP=0.
  - ST_ERR1: HREADYOUT=0, HRESP=1.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
- Transitions on a valid address phase, from ST_IDLE, ST_DATA or ST_ERR2:
  - illegal → ST_ERR1
  - WAIT_STATES=0 → ST_DATA
  - otherwise → ST_WAIT with cnt=WAIT_STATES
- ST_WAIT → ST_DATA when cnt==1.
- ST_ERR1 → ST_ERR2 unconditionally.
- ST_DATA and ST_ERR2 without a new valid address phase → ST_IDLE.
- Write is committed at the ST_DATA rising edge (end of the data phase), using HWDATA under a lane mask:
  - byte: 1<<HADDR[1:0]
  - halfword: HADDR[1] ? 1100 : 0011
  - word: 1111
- Reads: HRDATA = mem[captured index], full word, regardless of HSIZE; the master extracts lanes. HRDATA=0 in every state except ST_DATA of a read.
- Memory is asynchronous-read from the registered index, so a write immediately followed by a read of the same word returns the new data.
- Memory array is not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state ST_IDLE, cnt=0.
- Reset asserted mid-transfer aborts it: no write commits, and outputs return to reset values asynchronously.
- OKAY latency: the data phase lasts WAIT_STATES+1 cycles after the address-phase edge.
- ERROR always lasts exactly 2 data-phase cycles.
- Back-to-back transfers: the next address phase overlaps ST_DATA/ST_ERR2 and is accepted only when HREADY=1.
- A master that drops to IDLE during ST_ERR1 is legal; that IDLE is sampled in ST_ERR2 and the FSM returns to ST_IDLE.
- HREADY=0 from another slave (HSEL low): no capture, no state change out of ST_IDLE.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HSIZE_BYTE/HALF/WORD
  - HRESP_OKAY/ERROR
  - resp_state_t enum: ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2
- One sub-module, ahb_byte_strobe: HSIZE+HADDR[1:0] → 4-bit lane mask plus illegal flag.

## Test plan
- WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back → read data phase HRDATA=0xDEADBEEF, HREADYOUT never low.
- WAIT_STATES=3: read 0x04 → HREADYOUT low for 3 cycles, then 1 with data. HRDATA=0 during the wait cycles.
- Byte write 0xAA to 0x21, halfword write 0x5566 to 0x22 over word 0x00000000 → read 0x20 returns 0x5566AA00.
- Word write to 0x02 (misaligned) → HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1; word at 0x00 is unchanged. Repeat with HSIZE=11 and expect the same response.
- SEQ burst of 4 word writes 0x40..0x4C with WAIT_STATES=1, with a BUSY beat inserted → BUSY gets zero-wait OKAY, and all 4 words read back correctly.
- HRESETn low during ST_WAIT of a write → outputs go to their reset values immediately, and a later read of that address shows the old data.
